// File: rtl/mips_isa_pkg.sv
// MIPS ISA constants shared by the program loader and the control decoder.
package mips_isa_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned OP_W     = 6;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned IMM_W    = 16;
  localparam int unsigned TARGET_W = 26;
  localparam int unsigned KIND_W   = 4;

  // Primary opcodes
  localparam logic [OP_W-1:0] OP_SPECIAL = 6'h00;
  localparam logic [OP_W-1:0] OP_J       = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL     = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ     = 6'h04;
  localparam logic [OP_W-1:0] OP_ADDI    = 6'h08;
  localparam logic [OP_W-1:0] OP_ADDIU   = 6'h09;
  localparam logic [OP_W-1:0] OP_SLTI    = 6'h0A;
  localparam logic [OP_W-1:0] OP_SLTIU   = 6'h0B;
  localparam logic [OP_W-1:0] OP_ANDI    = 6'h0C;
  localparam logic [OP_W-1:0] OP_LUI     = 6'h0F;
  localparam logic [OP_W-1:0] OP_LW      = 6'h23;
  localparam logic [OP_W-1:0] OP_SW      = 6'h2B;

  // SPECIAL funct codes
  localparam logic [FUNCT_W-1:0] FN_SLL  = 6'h00;
  localparam logic [FUNCT_W-1:0] FN_SRL  = 6'h02;
  localparam logic [FUNCT_W-1:0] FN_SRA  = 6'h03;
  localparam logic [FUNCT_W-1:0] FN_JR   = 6'h08;
  localparam logic [FUNCT_W-1:0] FN_JALR = 6'h09;
  localparam logic [FUNCT_W-1:0] FN_ADD  = 6'h20;
  localparam logic [FUNCT_W-1:0] FN_ADDU = 6'h21;
  localparam logic [FUNCT_W-1:0] FN_SUB  = 6'h22;
  localparam logic [FUNCT_W-1:0] FN_SUBU = 6'h23;
  localparam logic [FUNCT_W-1:0] FN_AND  = 6'h24;
  localparam logic [FUNCT_W-1:0] FN_OR   = 6'h25;
  localparam logic [FUNCT_W-1:0] FN_XOR  = 6'h26;
  localparam logic [FUNCT_W-1:0] FN_NOR  = 6'h27;
  localparam logic [FUNCT_W-1:0] FN_SLT  = 6'h2A;
  localparam logic [FUNCT_W-1:0] FN_SLTU = 6'h2B;

  typedef enum logic [KIND_W-1:0] {
    KIND_RTYPE = 4'd0,
    KIND_SHIFT = 4'd1,
    KIND_JR    = 4'd2,
    KIND_JALR  = 4'd3,
    KIND_LW    = 4'd4,
    KIND_SW    = 4'd5,
    KIND_BEQ   = 4'd6,
    KIND_LUI   = 4'd7,
    KIND_ADDI  = 4'd8,
    KIND_ADDIU = 4'd9,
    KIND_ANDI  = 4'd10,
    KIND_SLTI  = 4'd11,
    KIND_SLTIU = 4'd12,
    KIND_J     = 4'd13,
    KIND_JAL   = 4'd14,
    KIND_NOP   = 4'd15
  } instrKind_e;

  // Instruction descriptor as presented to the encoder
  typedef struct packed {
    instrKind_e          kind;
    logic [REG_W-1:0]    rs;
    logic [REG_W-1:0]    rt;
    logic [REG_W-1:0]    rd;
    logic [REG_W-1:0]    shamt;
    logic [FUNCT_W-1:0]  funct;
    logic [IMM_W-1:0]    imm;
    logic [TARGET_W-1:0] target;
  } instrDesc_t;

  // Funct codes the core's ALU decoder actually implements for RTYPE
  function automatic logic isSupportedFunct(input logic [FUNCT_W-1:0] funct);
    case (funct)
      FN_SLL, FN_SRL, FN_SRA,
      FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
      FN_AND, FN_OR, FN_XOR, FN_NOR,
      FN_SLT, FN_SLTU: isSupportedFunct = 1'b1;
      default:         isSupportedFunct = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_instr_pack.sv
// Combinational encoder: instruction descriptor -> 32-bit MIPS word plus illegal flag.
module mips_instr_pack
  import mips_isa_pkg::*;
(
  input  instrDesc_t          desc,
  output logic [WORD_W-1:0]   word_c,
  output logic                illegal_c
);

  localparam logic [REG_W-1:0] ZERO_REG = '0;

  // Pack fields per instruction kind; imm and target are copied verbatim
  always_comb begin
    word_c    = '0;
    illegal_c = 1'b0;
    case (desc.kind)
      KIND_RTYPE: begin
        word_c    = {OP_SPECIAL, desc.rs, desc.rt, desc.rd, desc.shamt, desc.funct};
        illegal_c = ~isSupportedFunct(desc.funct);
      end
      KIND_SHIFT: word_c = {OP_SPECIAL, ZERO_REG, desc.rt, desc.rd, desc.shamt,
                            4'b0000, desc.funct[1:0]};
      KIND_JR:    word_c = {OP_SPECIAL, desc.rs, ZERO_REG, ZERO_REG, ZERO_REG, FN_JR};
      KIND_JALR:  word_c = {OP_SPECIAL, desc.rs, ZERO_REG, desc.rd, ZERO_REG, FN_JALR};
      KIND_LW:    word_c = {OP_LW,    desc.rs, desc.rt, desc.imm};
      KIND_SW:    word_c = {OP_SW,    desc.rs, desc.rt, desc.imm};
      KIND_BEQ:   word_c = {OP_BEQ,   desc.rs, desc.rt, desc.imm};
      KIND_LUI:   word_c = {OP_LUI,   ZERO_REG, desc.rt, desc.imm};
      KIND_ADDI:  word_c = {OP_ADDI,  desc.rs, desc.rt, desc.imm};
      KIND_ADDIU: word_c = {OP_ADDIU, desc.rs, desc.rt, desc.imm};
      KIND_ANDI:  word_c = {OP_ANDI,  desc.rs, desc.rt, desc.imm};
      KIND_SLTI:  word_c = {OP_SLTI,  desc.rs, desc.rt, desc.imm};
      KIND_SLTIU: word_c = {OP_SLTIU, desc.rs, desc.rt, desc.imm};
      KIND_J:     word_c = {OP_J,   desc.target};
      KIND_JAL:   word_c = {OP_JAL, desc.target};
      KIND_NOP:   word_c = '0;
      default:    word_c = '0;
    endcase
  end

endmodule

// File: rtl/mips_instr_loader.sv
// Boot/debug program loader: encodes descriptors and writes them sequentially into IMEM.
module mips_instr_loader
  import mips_isa_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned IMEM_DEPTH = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [KIND_W-1:0]   in_kind,
  input  logic [REG_W-1:0]    in_rs,
  input  logic [REG_W-1:0]    in_rt,
  input  logic [REG_W-1:0]    in_rd,
  input  logic [REG_W-1:0]    in_shamt,
  input  logic [FUNCT_W-1:0]  in_funct,
  input  logic [IMM_W-1:0]    in_imm,
  input  logic [TARGET_W-1:0] in_target,
  input  logic                in_last,
  output logic                imem_we,
  output logic [ADDR_W-1:0]   imem_addr,
  output logic [WORD_W-1:0]   imem_wdata,
  output logic                done,
  output logic                err_full,
  output logic                err_funct,
  output logic [ADDR_W:0]     words_written
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } loadState_e;

  loadState_e        state;
  loadState_e        stateNext;
  logic [ADDR_W-1:0] ptr;
  instrDesc_t        desc;
  logic [WORD_W-1:0] packedWord_c;
  logic              illegal_c;
  logic              atEnd;
  logic              loadStart;
  logic              doWrite;
  logic              finish;
  logic              setFull;
  logic              setFunct;

  assign desc = '{kind:   instrKind_e'(in_kind),
                  rs:     in_rs,
                  rt:     in_rt,
                  rd:     in_rd,
                  shamt:  in_shamt,
                  funct:  in_funct,
                  imm:    in_imm,
                  target: in_target};

  mips_instr_pack u_pack (
    .desc      (desc),
    .word_c    (packedWord_c),
    .illegal_c (illegal_c)
  );

  // Pointer saturates here; a write at this address ends the load
  assign atEnd = (ptr >= LAST_ADDR);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state and per-cycle control decode
  always_comb begin
    stateNext = state;
    loadStart = 1'b0;
    doWrite   = 1'b0;
    finish    = 1'b0;
    setFull   = 1'b0;
    setFunct  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          stateNext = RUN;
          loadStart = 1'b1;
        end
      end
      RUN: begin
        if (in_valid) begin
          doWrite  = ~illegal_c;
          setFunct = illegal_c;
          if (in_last) begin
            finish = 1'b1;
          end else if (!illegal_c && atEnd) begin
            finish  = 1'b1;
            setFull = 1'b1;
          end
          if (finish) stateNext = DONE;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Registered outputs, pointer and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr           <= '0;
      in_ready      <= 1'b0;
      imem_we       <= 1'b0;
      imem_addr     <= '0;
      imem_wdata    <= '0;
      done          <= 1'b0;
      err_full      <= 1'b0;
      err_funct     <= 1'b0;
      words_written <= '0;
    end else begin
      in_ready <= (stateNext == RUN);
      imem_we  <= doWrite;
      done     <= finish;
      if (doWrite) begin
        imem_addr     <= ptr;
        imem_wdata    <= packedWord_c;
        words_written <= words_written + CNT_W'(1);
        if (!atEnd) ptr <= ptr + ADDR_W'(1);
      end
      if (setFull)  err_full  <= 1'b1;
      if (setFunct) err_funct <= 1'b1;
      if (loadStart) begin
        ptr           <= base_addr;
        err_full      <= 1'b0;
        err_funct     <= 1'b0;
        words_written <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mips_instr_loader.sv
// Directed plus randomized bench for mips_instr_loader against a behavioural reference.
module tb_mips_instr_loader;

  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned IMEM_DEPTH = 256;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_kind;
  logic [4:0]        in_rs, in_rt, in_rd, in_shamt;
  logic [5:0]        in_funct;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              in_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              done;
  logic              err_full;
  logic              err_funct;
  logic [ADDR_W:0]   words_written;

  mips_instr_loader #(.ADDR_W(ADDR_W), .IMEM_DEPTH(IMEM_DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .done(done),
    .err_full(err_full), .err_funct(err_funct), .words_written(words_written)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state: phase 0 idle, 1 loading, 2 finishing
  int          mPhase = 0;
  int          mPtr   = 0;
  int          mCount = 0;
  bit          mFull  = 0;
  bit          mFunct = 0;
  bit          expWe, expDone;
  logic [31:0] expData = '0;
  int          expAddr = 0;

  int legalFuncts[13] = '{'h00, 'h02, 'h03, 'h20, 'h21, 'h22, 'h23,
                          'h24, 'h25, 'h26, 'h27, 'h2A, 'h2B};

  function automatic bit refLegal(input int kind, input int fn);
    if (kind != 0) return 1'b1;
    foreach (legalFuncts[i]) if (legalFuncts[i] == fn) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] refEncode(input int kind, input int rs, input int rt,
                                            input int rd, input int sh, input int fn,
                                            input int im, input int tg);
    logic [31:0] r;
    int op;
    r  = 32'(rs) * 32'h20_0000 + 32'(rt) * 32'h1_0000 + 32'(im);
    op = 0;
    case (kind)
      0:  return 32'(rs) * 32'h20_0000 + 32'(rt) * 32'h1_0000 + 32'(rd) * 32'h800
                 + 32'(sh) * 32'h40 + 32'(fn);
      1:  return 32'(rt) * 32'h1_0000 + 32'(rd) * 32'h800 + 32'(sh) * 32'h40 + 32'(fn % 4);
      2:  return 32'(rs) * 32'h20_0000 + 32'd8;
      3:  return 32'(rs) * 32'h20_0000 + 32'(rd) * 32'h800 + 32'd9;
      4:  op = 'h23;
      5:  op = 'h2B;
      6:  op = 'h04;
      7:  return 32'h0F * 32'h400_0000 + 32'(rt) * 32'h1_0000 + 32'(im);
      8:  op = 'h08;
      9:  op = 'h09;
      10: op = 'h0C;
      11: op = 'h0A;
      12: op = 'h0B;
      13: return 32'h0800_0000 + 32'(tg);
      14: return 32'h0C00_0000 + 32'(tg);
      default: return 32'h0;
    endcase
    return 32'(op) * 32'h400_0000 + r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, update the reference with the inputs that were live at the edge, compare
  task automatic tick();
    bit legal;
    @(posedge clk);
    expWe   = 0;
    expDone = 0;
    if (reset) begin
      mPhase = 0; mPtr = 0; mCount = 0; mFull = 0; mFunct = 0;
      expAddr = 0; expData = '0;
    end else begin
      case (mPhase)
        0: if (start) begin
             mPhase = 1; mPtr = int'(base_addr); mCount = 0; mFull = 0; mFunct = 0;
           end
        1: if (in_valid) begin
             legal = refLegal(int'(in_kind), int'(in_funct));
             if (legal) begin
               expWe   = 1;
               expAddr = mPtr;
               expData = refEncode(int'(in_kind), int'(in_rs), int'(in_rt), int'(in_rd),
                                   int'(in_shamt), int'(in_funct), int'(in_imm), int'(in_target));
               mCount++;
             end else begin
               mFunct = 1;
             end
             if (in_last) begin
               expDone = 1; mPhase = 2;
             end else if (legal && mPtr == IMEM_DEPTH - 1) begin
               expDone = 1; mFull = 1; mPhase = 2;
             end
             if (legal && mPtr < IMEM_DEPTH - 1) mPtr++;
           end
        default: mPhase = 0;
      endcase
    end
    #1;
    chk("in_ready", 64'(in_ready), 64'(mPhase == 1));
    chk("imem_we", 64'(imem_we), 64'(expWe));
    chk("imem_addr", 64'(imem_addr), 64'(expAddr));
    chk("imem_wdata", 64'(imem_wdata), 64'(expData));
    chk("done", 64'(done), 64'(expDone));
    chk("err_full", 64'(err_full), 64'(mFull));
    chk("err_funct", 64'(err_funct), 64'(mFunct));
    chk("words_written", 64'(words_written), 64'(mCount));
  endtask

  task automatic setDesc(input int kind, input int rs, input int rt, input int rd,
                         input int sh, input int fn, input int im, input int tg,
                         input bit last);
    in_valid  = 1'b1;
    in_kind   = 4'(kind);
    in_rs     = 5'(rs);
    in_rt     = 5'(rt);
    in_rd     = 5'(rd);
    in_shamt  = 5'(sh);
    in_funct  = 6'(fn);
    in_imm    = 16'(im);
    in_target = 26'(tg);
    in_last   = last;
  endtask

  task automatic doStart(input int base);
    start     = 1'b1;
    base_addr = ADDR_W'(base);
    tick();
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0;
    in_valid = 1'b0; in_kind = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0;
    in_funct = '0; in_imm = '0; in_target = '0; in_last = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Single LW, last
    doStart('h10);
    setDesc(4, 29, 8, 0, 0, 0, 'h0004, 0, 1);
    tick();
    chk("lw_word", 64'(imem_wdata), 64'h8FA8_0004);
    chk("lw_addr", 64'(imem_addr), 64'h10);
    idle(2);

    // BEQ, JAL, JR stream
    doStart('h20);
    setDesc(6, 1, 2, 0, 0, 0, 'hFFFF, 0, 0);
    tick();
    chk("beq_word", 64'(imem_wdata), 64'h1022_FFFF);
    setDesc(14, 0, 0, 0, 0, 0, 0, 'h0000010, 0);
    tick();
    chk("jal_word", 64'(imem_wdata), 64'h0C00_0010);
    setDesc(2, 31, 0, 0, 0, 0, 0, 0, 1);
    tick();
    chk("jr_word", 64'(imem_wdata), 64'h03E0_0008);
    chk("stream_count", 64'(words_written), 64'd3);
    idle(2);

    // RTYPE, SHIFT, LUI
    doStart('h40);
    setDesc(0, 1, 2, 3, 0, 'h21, 0, 0, 0);
    tick();
    chk("rtype_word", 64'(imem_wdata), 64'h0022_1821);
    setDesc(1, 0, 3, 2, 4, 'h00, 0, 0, 0);
    tick();
    chk("shift_word", 64'(imem_wdata), 64'h0003_1100);
    setDesc(7, 0, 1, 0, 0, 0, 'h1234, 0, 1);
    tick();
    chk("lui_word", 64'(imem_wdata), 64'h3C01_1234);
    idle(2);

    // Illegal funct sandwiched between NOPs
    doStart('h50);
    setDesc(15, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    setDesc(0, 4, 5, 6, 0, 'h08, 0, 0, 0);
    tick();
    setDesc(15, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    chk("illegal_addr", 64'(imem_addr), 64'h51);
    chk("illegal_err", 64'(err_funct), 64'd1);
    chk("illegal_count", 64'(words_written), 64'd2);
    idle(2);

    // Memory end reached before last
    doStart(IMEM_DEPTH - 2);
    setDesc(8, 1, 1, 0, 0, 0, 'h0001, 0, 0);
    tick();
    setDesc(9, 2, 2, 0, 0, 0, 'h0002, 0, 0);
    tick();
    chk("full_done", 64'(done), 64'd1);
    chk("full_addr", 64'(imem_addr), 64'(IMEM_DEPTH - 1));
    setDesc(10, 3, 3, 0, 0, 0, 'h0003, 0, 0);
    tick();
    chk("full_ready_off", 64'(in_ready), 64'd0);
    tick();
    chk("full_count", 64'(words_written), 64'd2);
    idle(1);

    // Reset mid-stream and start ignored while running
    doStart('h80);
    setDesc(11, 1, 2, 0, 0, 0, 'h7FFF, 0, 0);
    tick();
    start = 1'b1; base_addr = 'h05;
    setDesc(12, 1, 2, 0, 0, 0, 'h8000, 0, 0);
    tick();
    start = 1'b0;
    chk("start_ignored_addr", 64'(imem_addr), 64'h81);
    reset = 1'b1;
    tick();
    chk("reset_we", 64'(imem_we), 64'd0);
    chk("reset_ready", 64'(in_ready), 64'd0);
    reset = 1'b0;
    idle(2);

    // Randomized traffic, including spurious starts and occasional resets
    for (int c = 0; c < 3000; c++) begin
      int k;
      int fn;
      start     = ($urandom_range(0, 3) == 0);
      base_addr = ADDR_W'($urandom_range(0, IMEM_DEPTH - 1));
      reset     = ($urandom_range(0, 199) == 0);
      k  = int'($urandom_range(0, 15));
      fn = ($urandom_range(0, 1) == 0) ? legalFuncts[$urandom_range(0, 12)]
                                       : int'($urandom_range(0, 63));
      setDesc(k, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), fn,
              int'($urandom_range(0, 'hFFFF)), int'($urandom_range(0, 'h3FF_FFFF)),
              ($urandom_range(0, 15) == 0));
      in_valid = ($urandom_range(0, 3) != 0);
      tick();
    end
    reset = 1'b0;
    start = 1'b0;
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
